// File: rtl/b09_serial_framer.sv
// b09_serial_framer: parallel-to-serial framer feeding the b09 serial input X.
// Each byte goes out as a 1 start marker, 8 data bits LSB first, then an idle gap.
//
// Parameters:
//   GAP_CYCLES  extra idle zeros after each frame (0..15)
//   FIFO_DEPTH  buffer depth in bytes (power of two, 2..16), FIFO build only
//   CNT_W       width of frame_count
// Ports:
//   clock        rising-edge clock shared with b09
//   reset_n      asynchronous active-low reset
//   din          byte to transmit
//   din_valid    din is valid
//   din_ready    a byte can be accepted this cycle (depends on occupancy only)
//   X            registered serial output
//   busy         frame in flight or byte buffered
//   frame_count  completed frames, wraps
// Build option: define B09_FRAMER_FIFO_EN for a FIFO_DEPTH-entry circular FIFO;
// otherwise a single holding register buffers one byte.

module b09_serial_framer #(
    parameter int GAP_CYCLES = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             X,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        GAP
    } state_t;

    localparam logic [3:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic [3:0] gap_cnt;

    logic       push;
    logic       pop;
    logic       buf_empty;
    logic [7:0] head;

    assign push = din_valid && din_ready;
    // Pop decision uses registered occupancy, so a byte pushed at this
    // edge into an empty buffer is only seen at the next edge.
    assign pop  = (state == IDLE) && !buf_empty;
    assign busy = (state != IDLE) || !buf_empty;

`ifdef B09_FRAMER_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    assign din_ready = (occ != FULL);
    assign buf_empty = (occ == '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    assign din_ready = !hold_valid;
    assign buf_empty = !hold_valid;
    assign head      = hold_data;

    // push needs an empty holder and pop a full one, so they never coincide
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'd0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= din;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            X           <= 1'b0;
            shreg       <= 8'd0;
            bit_idx     <= 3'd0;
            gap_cnt     <= 4'd0;
            frame_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    X <= 1'b0;
                    if (pop) begin
                        shreg <= head;
                        X     <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    X       <= shreg[0];
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= 3'd0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        X           <= 1'b0;
                        frame_count <= frame_count + 1'b1;
                        gap_cnt     <= 4'd0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        X       <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                GAP: begin
                    X <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    X     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b09_serial_framer.sv
// tb_b09_serial_framer: randomized self-checking bench for b09_serial_framer.
// A frame-level reference model predicts X, busy, frame_count and din_ready.

module tb_b09_serial_framer;

    localparam int G  = 2;
    localparam int D  = 4;
    localparam int CW = 16;
`ifdef B09_FRAMER_FIFO_EN
    localparam int CAP = D;
`else
    localparam int CAP = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    din = 8'd0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          X;
    logic          busy;
    logic [CW-1:0] frame_count;

    logic          din_valid2 = 1'b0;
    logic [7:0]    din2 = 8'd0;
    logic          din_ready2;
    logic          x2;
    logic          busy2;
    logic [CW-1:0] frame_count2;

    b09_serial_framer #(
        .GAP_CYCLES(G),
        .FIFO_DEPTH(D),
        .CNT_W(CW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .X(X),
        .busy(busy),
        .frame_count(frame_count)
    );

    b09_serial_framer #(
        .GAP_CYCLES(0),
        .FIFO_DEPTH(D),
        .CNT_W(CW)
    ) dut_g0 (
        .clock(clock),
        .reset_n(reset_n),
        .din(din2),
        .din_valid(din_valid2),
        .din_ready(din_ready2),
        .X(x2),
        .busy(busy2),
        .frame_count(frame_count2)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: byte queue plus the edge index of the last pop
    logic [7:0]    q[$];
    int            e_n;
    int            last_pop;
    int            next_ok;
    logic [8:0]    bits;
    logic [CW-1:0] m_cnt;
    logic          m_x;
    logic          m_busy;
    logic          m_ready;

    task automatic model_reset();
        q.delete();
        e_n      = 0;
        last_pop = -1000;
        next_ok  = 0;
        bits     = 9'd0;
        m_cnt    = '0;
        m_x      = 1'b0;
        m_busy   = 1'b0;
        m_ready  = 1'b1;
    endtask

    // one clock: drive inputs, take the edge, advance the model
    task automatic cyc(input logic v, input logic [7:0] d, output logic acc);
        int k;
        din_valid = v;
        din       = d;
        @(posedge clock);
        acc = v && (q.size() < CAP);
        if (q.size() > 0 && e_n >= next_ok) begin
            bits     = {q.pop_front(), 1'b1};
            last_pop = e_n;
            next_ok  = e_n + 10 + G;
        end
        if (acc) q.push_back(d);
        if (e_n == last_pop + 9) m_cnt = m_cnt + 1'b1;
        k       = e_n - last_pop;
        m_x     = (k >= 0 && k <= 8) ? bits[k] : 1'b0;
        m_busy  = (e_n < next_ok - 1) || (q.size() != 0);
        m_ready = (q.size() < CAP);
        e_n++;
        #1;
    endtask

    task automatic test_reset();
        logic acc;
        reset_n    = 1'b0;
        din_valid  = 1'b0;
        din_valid2 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if ({X, busy, frame_count, din_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_vals X=%b busy=%b cnt=%0d rdy=%b want 0 0 0 1",
                     X, busy, frame_count, din_ready);
        end
        reset_n = 1'b1;
        model_reset();
        repeat (20) begin
            cyc(1'b0, 8'd0, acc);
            n_tests++;
            if ({X, busy, frame_count, din_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL idle X=%b busy=%b cnt=%0d rdy=%b want 0 0 0 1",
                         X, busy, frame_count, din_ready);
            end
        end
    endtask

    task automatic test_single();
        logic          acc;
        logic [8:0]    seq;
        logic [CW-1:0] c0;
        seq = 9'b101001011;
        c0  = frame_count;
        cyc(1'b1, 8'hA5, acc);
        n_tests++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept model_acc=%b want 1", acc);
        end
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, 8'd0, acc);
            n_tests++;
            if (X !== seq[k] || X !== m_x) begin
                n_fail++;
                $display("FAIL single_bit%0d X=%b want %b", k, X, seq[k]);
            end
        end
        cyc(1'b0, 8'd0, acc);
        n_tests++;
        if (X !== 1'b0 || frame_count !== c0 + 1'b1) begin
            n_fail++;
            $display("FAIL single_end X=%b cnt=%0d want 0 %0d",
                     X, frame_count, c0 + 1'b1);
        end
        for (int i = 0; i < 40 && m_busy; i++) cyc(1'b0, 8'd0, acc);
    endtask

    task automatic test_back_to_back();
        logic [7:0]    pat[4];
        logic          acc;
        logic [CW-1:0] c0;
        logic [CW-1:0] prev;
        int            inc[$];
        int            t;
        pat  = '{8'h01, 8'h80, 8'hFF, 8'h00};
        c0   = frame_count;
        prev = frame_count;
        t    = 0;
        for (int b = 0; b < 4; b++) begin
            acc = 1'b0;
            for (int i = 0; i < 30 && !acc; i++) begin
                cyc(1'b1, pat[b], acc);
                t++;
                if (frame_count !== prev) inc.push_back(t);
                prev = frame_count;
                n_tests++;
                if ({X, busy, frame_count, din_ready} !== {m_x, m_busy, m_cnt, m_ready}) begin
                    n_fail++;
                    $display("FAIL b2b_push X=%b busy=%b cnt=%0d rdy=%b want %b %b %0d %b",
                             X, busy, frame_count, din_ready, m_x, m_busy, m_cnt, m_ready);
                end
            end
            n_tests++;
            if (!acc) begin
                n_fail++;
                $display("FAIL b2b_accept byte %0d timeout want accepted", b);
            end
        end
        for (int i = 0; i < 80 && m_busy; i++) begin
            cyc(1'b0, 8'd0, acc);
            t++;
            if (frame_count !== prev) inc.push_back(t);
            prev = frame_count;
            n_tests++;
            if ({X, busy, frame_count, din_ready} !== {m_x, m_busy, m_cnt, m_ready}) begin
                n_fail++;
                $display("FAIL b2b_drain X=%b busy=%b cnt=%0d rdy=%b want %b %b %0d %b",
                         X, busy, frame_count, din_ready, m_x, m_busy, m_cnt, m_ready);
            end
        end
        n_tests++;
        if (frame_count - c0 !== 16'd4 || inc.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count frames=%0d incs=%0d want 4 4",
                     frame_count - c0, inc.size());
        end
        for (int i = 1; i < inc.size(); i++) begin
            n_tests++;
            if (inc[i] - inc[i-1] != 10 + G) begin
                n_fail++;
                $display("FAIL b2b_period got %0d want %0d",
                         inc[i] - inc[i-1], 10 + G);
            end
        end
    endtask

    task automatic test_backpressure();
        logic          acc;
        logic [7:0]    nxt;
        int            n_acc;
        int            early;
        logic [CW-1:0] c0;
        nxt   = 8'h10;
        n_acc = 0;
        early = 0;
        c0    = frame_count;
        for (int i = 0; i < 10 * (10 + G) + 2; i++) begin
            cyc(1'b1, nxt, acc);
            if (acc) begin
                nxt = nxt + 1'b1;
                n_acc++;
                if (i < 8) early++;
            end
            n_tests++;
            if ({X, busy, frame_count, din_ready} !== {m_x, m_busy, m_cnt, m_ready}) begin
                n_fail++;
                $display("FAIL bp_hold X=%b busy=%b cnt=%0d rdy=%b want %b %b %0d %b",
                         X, busy, frame_count, din_ready, m_x, m_busy, m_cnt, m_ready);
            end
        end
        n_tests++;
        if (early != CAP + 1) begin
            n_fail++;
            $display("FAIL bp_fill accepted=%0d want %0d", early, CAP + 1);
        end
        for (int i = 0; i < 12 * (CAP + 2) && m_busy; i++) begin
            cyc(1'b0, 8'd0, acc);
            n_tests++;
            if ({X, busy, frame_count, din_ready} !== {m_x, m_busy, m_cnt, m_ready}) begin
                n_fail++;
                $display("FAIL bp_drain X=%b busy=%b cnt=%0d rdy=%b want %b %b %0d %b",
                         X, busy, frame_count, din_ready, m_x, m_busy, m_cnt, m_ready);
            end
        end
        n_tests++;
        if (int'(frame_count - c0) != n_acc || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_total frames=%0d busy=%b want %0d 0",
                     frame_count - c0, busy, n_acc);
        end
    endtask

    task automatic test_random();
        logic acc;
        logic v;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 99) < 40);
            cyc(v, 8'($urandom), acc);
            n_tests++;
            if ({X, busy, frame_count, din_ready} !== {m_x, m_busy, m_cnt, m_ready}) begin
                n_fail++;
                $display("FAIL rand X=%b busy=%b cnt=%0d rdy=%b want %b %b %0d %b",
                         X, busy, frame_count, din_ready, m_x, m_busy, m_cnt, m_ready);
            end
        end
        for (int i = 0; i < 12 * (CAP + 2) && m_busy; i++) cyc(1'b0, 8'd0, acc);
    endtask

    task automatic test_gap0();
        logic [7:0]    a;
        logic [7:0]    b;
        logic          b_done;
        logic          ev[22];
        logic          obs[22];
        logic [CW-1:0] c0;
        a      = 8'($urandom);
        b      = 8'($urandom);
        b_done = 1'b0;
        c0     = frame_count2;
        for (int k = 0; k < 22; k++) ev[k] = 1'b0;
        ev[1]  = 1'b1;
        ev[11] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ev[2 + k]  = a[k];
            ev[12 + k] = b[k];
        end
        for (int i = 0; i < 22; i++) begin
            if (i == 0) begin
                din_valid2 = 1'b1;
                din2       = a;
                n_tests++;
                if (din_ready2 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL g0_ready got %b want 1", din_ready2);
                end
            end else if (!b_done) begin
                din_valid2 = 1'b1;
                din2       = b;
            end else begin
                din_valid2 = 1'b0;
            end
            @(posedge clock);
            if (i > 0 && din_valid2 && din_ready2) b_done = 1'b1;
            #1;
            obs[i] = x2;
        end
        din_valid2 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            n_tests++;
            if (obs[i] !== ev[i]) begin
                n_fail++;
                $display("FAIL g0_x edge+%0d got %b want %b", i, obs[i], ev[i]);
            end
        end
        n_tests++;
        if (frame_count2 - c0 !== 16'd2 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL g0_end frames=%0d busy=%b want 2 0",
                     frame_count2 - c0, busy2);
        end
    endtask

    task automatic test_reset_mid();
        logic       acc;
        logic [7:0] src[$];
        logic       hit;
        src = '{8'h3C, 8'($urandom), 8'($urandom)};
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc(src.size() > 0, (src.size() > 0) ? src[0] : 8'd0, acc);
            if (acc) void'(src.pop_front());
            hit = (e_n - 1 - last_pop == 4) && (bits == {8'h3C, 1'b1});
        end
        n_tests++;
        if (!hit || X !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_d3 reached=%b X=%b want 1 1", hit, X);
        end
        din_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({X, busy, frame_count, din_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_async X=%b busy=%b cnt=%0d rdy=%b want 0 0 0 1",
                     X, busy, frame_count, din_ready);
        end
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 8'd0, acc);
            n_tests++;
            if ({X, busy, frame_count, din_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL rst_mid_after X=%b busy=%b cnt=%0d rdy=%b want 0 0 0 1",
                         X, busy, frame_count, din_ready);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_gap0();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
